box_scanner: RTL and testbench

Pixel-walk stage that sits directly downstream of `boundingbox`. It accepts one rounded triangle bounding box (XMIN/XMAX/YMIN/YMAX, Q10.6 unsigned fixed point) over a valid/ready handshake. It then emits every integer pixel coordinate inside the box, in row-major order, one per cycle, to the edge-function test stage. It turns the bounding box from a static result into a pixel stream and owns all iteration state for one triangle.

---
 rtl/raster_pkg.sv | 14 +
 rtl/scan_axis_counter.sv | 45 ++++
 rtl/box_scanner.sv | 140 ++++++++++++++
 tb/tb_box_scanner.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared rasterizer types: fixed-point layout, pixel step and the scan FSM states.
package raster_pkg;

  localparam int FRAC_BITS = 6;
  localparam int PIX_STEP  = 1 << FRAC_BITS;

  typedef logic [15:0] coord_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/scan_axis_counter.sv
// One axis of the pixel walk: loadable position register with latched min/max,
// fixed-step increment, reload-to-min and an equality-based at_max flag.
module scan_axis_counter
  import raster_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = PIX_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_min,
  input  logic [WIDTH-1:0] load_max,
  input  logic             step,
  input  logic             reload,
  output logic [WIDTH-1:0] value,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      min_q <= '0;
      max_q <= '0;
    end else if (load) begin
      value <= load_min;
      min_q <= load_min;
      max_q <= load_max;
    end else if (reload) begin
      value <= min_q;
    end else if (step) begin
      value <= value + STEP_W;
    end
  end

  // Equality against the latched maximum, so a maximum at the top of the
  // coordinate range ends the walk before the adder can wrap.
  assign at_max = (value == max_q);

endmodule

// File: rtl/box_scanner.sv
// Walks every integer pixel of an accepted bounding box in row-major order.
// Optional screen clamping of the maxima is compiled in with BOX_SCANNER_CLIP_EN.
module box_scanner #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = raster_pkg::FRAC_BITS,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             box_valid,
  output logic             box_ready,
  input  logic [WIDTH-1:0] xmin,
  input  logic [WIDTH-1:0] xmax,
  input  logic [WIDTH-1:0] ymin,
  input  logic [WIDTH-1:0] ymax,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [WIDTH-1:0] px,
  output logic [WIDTH-1:0] py,
  output logic             pix_last,
  output logic             busy
);

  import raster_pkg::*;

  localparam int               STEP      = 1 << FRAC_BITS;
  localparam logic [WIDTH-1:0] FRAC_MASK = ~(WIDTH'(STEP - 1));
  localparam logic [WIDTH-1:0] X_LIMIT   = WIDTH'((SCREEN_W - 1) << FRAC_BITS);
  localparam logic [WIDTH-1:0] Y_LIMIT   = WIDTH'((SCREEN_H - 1) << FRAC_BITS);

`ifdef BOX_SCANNER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  scan_state_t state;
  scan_state_t state_nxt;

  logic [WIDTH-1:0] xmin_m;
  logic [WIDTH-1:0] xmax_m;
  logic [WIDTH-1:0] ymin_m;
  logic [WIDTH-1:0] ymax_m;
  logic             box_empty;

  logic load;
  logic x_step;
  logic x_reload;
  logic y_step;
  logic x_at_max;
  logic y_at_max;

  // Fraction bits are dropped first; the empty test sees the clamped maxima
  // so a box entirely off the right or bottom of the screen emits nothing.
  always_comb begin
    xmin_m = xmin & FRAC_MASK;
    ymin_m = ymin & FRAC_MASK;
    xmax_m = xmax & FRAC_MASK;
    ymax_m = ymax & FRAC_MASK;
    if (CLIP_EN && (xmax_m > X_LIMIT)) xmax_m = X_LIMIT;
    if (CLIP_EN && (ymax_m > Y_LIMIT)) ymax_m = Y_LIMIT;
    box_empty = (xmin_m > xmax_m) || (ymin_m > ymax_m);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs depend on state alone; pix_ready and box_valid only
  // steer the counters and the next state.
  always_comb begin
    state_nxt = state;
    box_ready = 1'b0;
    pix_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    x_step    = 1'b0;
    x_reload  = 1'b0;
    y_step    = 1'b0;
    case (state)
      IDLE: begin
        box_ready = 1'b1;
        if (box_valid && !box_empty) begin
          load      = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        pix_valid = 1'b1;
        busy      = 1'b1;
        if (pix_ready) begin
          if (!x_at_max) begin
            x_step = 1'b1;
          end else if (!y_at_max) begin
            x_reload = 1'b1;
            y_step   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  scan_axis_counter #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_x_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_min (xmin_m),
    .load_max (xmax_m),
    .step     (x_step),
    .reload   (x_reload),
    .value    (px),
    .at_max   (x_at_max)
  );

  scan_axis_counter #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_y_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_min (ymin_m),
    .load_max (ymax_m),
    .step     (y_step),
    .reload   (1'b0),
    .value    (py),
    .at_max   (y_at_max)
  );

  assign pix_last = pix_valid & x_at_max & y_at_max;

endmodule

// File: tb/tb_box_scanner.sv
// Randomized self-checking bench for box_scanner against a loop-based pixel list model.
module tb_box_scanner;
  import raster_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   box_valid;
  logic   box_ready;
  coord_t xmin, xmax, ymin, ymax;
  logic   pix_valid;
  logic   pix_ready;
  coord_t px, py;
  logic   pix_last;
  logic   busy;

  int n_checks = 0;
  int n_fail   = 0;

  coord_t obs_x[$], obs_y[$], exp_x[$], exp_y[$];
  bit     obs_last[$], exp_last[$];
  int     stall_err, busy_err, scan_cycles;
  bit     timed_out;

  always #5 clk = ~clk;

  box_scanner dut (
    .clk       (clk),
    .rst       (rst),
    .box_valid (box_valid),
    .box_ready (box_ready),
    .xmin      (xmin),
    .xmax      (xmax),
    .ymin      (ymin),
    .ymax      (ymax),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .px        (px),
    .py        (py),
    .pix_last  (pix_last),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: every 64-aligned point of the masked (and optionally clamped)
  // box, row by row, with the final one flagged.
  task automatic build_expected(input coord_t xmn, input coord_t xmx,
                                input coord_t ymn, input coord_t ymx);
    int xa, xb, ya, yb;
    exp_x.delete(); exp_y.delete(); exp_last.delete();
    xa = int'(xmn) / 64 * 64;
    xb = int'(xmx) / 64 * 64;
    ya = int'(ymn) / 64 * 64;
    yb = int'(ymx) / 64 * 64;
`ifdef BOX_SCANNER_CLIP_EN
    if (xb > 639 * 64) xb = 639 * 64;
    if (yb > 479 * 64) yb = 479 * 64;
`endif
    if (xa > xb || ya > yb) return;
    for (int y = ya; y <= yb; y += 64)
      for (int x = xa; x <= xb; x += 64) begin
        exp_x.push_back(coord_t'(x));
        exp_y.push_back(coord_t'(y));
        exp_last.push_back(x == xb && y == yb);
      end
  endtask

  // Offers one box, then records every pixel handshake until PIX_VALID drops.
  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic run_box(input coord_t xmn, input coord_t xmx, input coord_t ymn,
                         input coord_t ymx, input int mode, input int budget);
    bit     prev_stall, done, rdy;
    coord_t hold_x, hold_y;
    logic   hold_last;
    int     k;
    obs_x.delete(); obs_y.delete(); obs_last.delete();
    stall_err = 0; busy_err = 0; scan_cycles = 0;
    prev_stall = 0; done = 0; k = 0;
    hold_x = '0; hold_y = '0; hold_last = 1'b0;
    xmin = xmn; xmax = xmx; ymin = ymn; ymax = ymx;
    box_valid = 1'b1;
    pix_ready = 1'b0;
    tick();
    box_valid = 1'b0;
    xmin = coord_t'($urandom); xmax = coord_t'($urandom);
    ymin = coord_t'($urandom); ymax = coord_t'($urandom);
    while (!done && scan_cycles < budget) begin
      if (pix_valid !== 1'b1) begin
        done = 1;
      end else begin
        if (box_ready !== 1'b0 || busy !== 1'b1) busy_err++;
        if (prev_stall && (px !== hold_x || py !== hold_y || pix_last !== hold_last))
          stall_err++;
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (k % 3 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        k++;
        pix_ready = rdy;
        if (rdy) begin
          obs_x.push_back(px); obs_y.push_back(py); obs_last.push_back(pix_last);
          prev_stall = 0;
        end else begin
          prev_stall = 1; hold_x = px; hold_y = py; hold_last = pix_last;
        end
        tick();
        scan_cycles++;
      end
    end
    pix_ready = 1'b0;
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1; box_valid = 1'b0; pix_ready = 1'b0;
    xmin = '0; xmax = '0; ymin = '0; ymax = '0;
    repeat (3) tick();
    n_checks++; if (box_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset box_ready: got %b, expected 1", box_ready); end
    n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset pix_valid: got %b, expected 0", pix_valid); end
    n_checks++; if (pix_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset pix_last: got %b, expected 0", pix_last); end
    n_checks++; if (px !== 16'd0 || py !== 16'd0) begin n_fail++; $display("[TB] FAIL reset px/py: got %0d,%0d, expected 0,0", px, py); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset busy: got %b, expected 0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_row();
    run_box(16'd64, 16'd128, 16'd64, 16'd64, 0, 50);
    build_expected(16'd64, 16'd128, 16'd64, 16'd64);
    n_checks++; if (obs_x.size() !== exp_x.size()) begin n_fail++; $display("[TB] FAIL row count: got %0d, expected %0d", obs_x.size(), exp_x.size()); end
    else foreach (exp_x[i]) begin
      n_checks++;
      if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_last[i] !== exp_last[i]) begin
        n_fail++; $display("[TB] FAIL row pixel %0d: got (%0d,%0d,%b), expected (%0d,%0d,%b)", i, obs_x[i], obs_y[i], obs_last[i], exp_x[i], exp_y[i], exp_last[i]);
      end
    end
    n_checks++; if (scan_cycles !== 2) begin n_fail++; $display("[TB] FAIL row scan cycles: got %0d, expected 2", scan_cycles); end
    n_checks++; if (box_ready !== 1'b1 || pix_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL row return to idle: got ready=%b valid=%b, expected 1,0", box_ready, pix_valid); end
    n_checks++; if (busy_err !== 0) begin n_fail++; $display("[TB] FAIL row busy/ready in scan: got %0d bad cycles, expected 0", busy_err); end
  endtask

  task automatic test_empty();
    run_box(16'd128, 16'd64, 16'd0, 16'd0, 0, 10);
    n_checks++; if (obs_x.size() !== 0) begin n_fail++; $display("[TB] FAIL empty-x pixels: got %0d, expected 0", obs_x.size()); end
    run_box(16'd0, 16'd0, 16'd191, 16'd64, 0, 10);
    n_checks++; if (obs_x.size() !== 0) begin n_fail++; $display("[TB] FAIL empty-y pixels: got %0d, expected 0", obs_x.size()); end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (box_ready !== 1'b1 || pix_valid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL empty idle cycle %0d: got ready=%b valid=%b, expected 1,0", c, box_ready, pix_valid);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    run_box(16'd0, 16'd128, 16'd0, 16'd64, 1, 100);
    build_expected(16'd0, 16'd128, 16'd0, 16'd64);
    n_checks++; if (obs_x.size() !== 6 || exp_x.size() !== 6) begin n_fail++; $display("[TB] FAIL stall count: got %0d, expected 6", obs_x.size()); end
    else foreach (exp_x[i]) begin
      n_checks++;
      if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_last[i] !== exp_last[i]) begin
        n_fail++; $display("[TB] FAIL stall pixel %0d: got (%0d,%0d,%b), expected (%0d,%0d,%b)", i, obs_x[i], obs_y[i], obs_last[i], exp_x[i], exp_y[i], exp_last[i]);
      end
    end
    n_checks++; if (stall_err !== 0) begin n_fail++; $display("[TB] FAIL stall hold: got %0d unstable cycles, expected 0", stall_err); end
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("[TB] FAIL stall timeout: got %b, expected 0", timed_out); end
  endtask

  task automatic test_top_edge();
    run_box(16'hFFC0, 16'hFFC0, 16'd0, 16'd64, 0, 20);
    build_expected(16'hFFC0, 16'hFFC0, 16'd0, 16'd64);
    n_checks++; if (obs_x.size() !== exp_x.size()) begin n_fail++; $display("[TB] FAIL edge count: got %0d, expected %0d", obs_x.size(), exp_x.size()); end
    else foreach (exp_x[i]) begin
      n_checks++;
      if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_last[i] !== exp_last[i]) begin
        n_fail++; $display("[TB] FAIL edge pixel %0d: got (%0d,%0d,%b), expected (%0d,%0d,%b)", i, obs_x[i], obs_y[i], obs_last[i], exp_x[i], exp_y[i], exp_last[i]);
      end
    end
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("[TB] FAIL edge termination: got timeout=%b, expected 0", timed_out); end
  endtask

  task automatic test_reset_midscan();
    xmin = 16'd0; xmax = 16'd192; ymin = 16'd0; ymax = 16'd192;
    box_valid = 1'b1; pix_ready = 1'b1;
    tick();
    box_valid = 1'b0;
    tick();
    tick();
    n_checks++; if (px !== 16'd128 || py !== 16'd0 || pix_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL midscan third pixel: got (%0d,%0d) valid=%b, expected (128,0) valid=1", px, py, pix_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0; pix_ready = 1'b0;
    n_checks++; if (pix_valid !== 1'b0 || box_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midscan reset: got valid=%b ready=%b busy=%b, expected 0,1,0", pix_valid, box_ready, busy); end
    run_box(16'd320, 16'd320, 16'd192, 16'd192, 0, 10);
    build_expected(16'd320, 16'd320, 16'd192, 16'd192);
    n_checks++; if (obs_x.size() !== 1 || exp_x.size() !== 1) begin n_fail++; $display("[TB] FAIL post-reset count: got %0d, expected 1", obs_x.size()); end
    else begin
      n_checks++;
      if (obs_x[0] !== exp_x[0] || obs_y[0] !== exp_y[0] || obs_last[0] !== exp_last[0]) begin
        n_fail++; $display("[TB] FAIL post-reset pixel: got (%0d,%0d,%b), expected (%0d,%0d,%b)", obs_x[0], obs_y[0], obs_last[0], exp_x[0], exp_y[0], exp_last[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    coord_t xa, xb, ya, yb, t;
    int w, h, mode;
    for (int b = 0; b < 30; b++) begin
      w  = $urandom_range(1, 6);
      h  = $urandom_range(1, 5);
      xa = coord_t'($urandom_range(0, 700) * 64);
      ya = coord_t'($urandom_range(0, 500) * 64);
      if (b % 10 == 9) xa = 16'hFFC0 - coord_t'((w - 1) * 64);
      xb = xa + coord_t'((w - 1) * 64) + coord_t'($urandom_range(0, 63));
      yb = ya + coord_t'((h - 1) * 64) + coord_t'($urandom_range(0, 63));
      xa = xa | coord_t'($urandom_range(0, 63));
      ya = ya | coord_t'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0 && w > 1) begin t = xa; xa = xb; xb = t; end
      mode = $urandom_range(0, 2);
      run_box(xa, xb, ya, yb, mode, w * h * 8 + 20);
      build_expected(xa, xb, ya, yb);
      n_checks++;
      if (obs_x.size() !== exp_x.size()) begin
        n_fail++; $display("[TB] FAIL random box %0d count: got %0d, expected %0d", b, obs_x.size(), exp_x.size());
      end else foreach (exp_x[i]) begin
        n_checks++;
        if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_last[i] !== exp_last[i]) begin
          n_fail++; $display("[TB] FAIL random box %0d pixel %0d: got (%0d,%0d,%b), expected (%0d,%0d,%b)", b, i, obs_x[i], obs_y[i], obs_last[i], exp_x[i], exp_y[i], exp_last[i]);
        end
      end
      n_checks++;
      if (stall_err !== 0 || busy_err !== 0) begin
        n_fail++; $display("[TB] FAIL random box %0d handshake: got stall=%0d busy=%0d, expected 0,0", b, stall_err, busy_err);
      end
      if (mode == 0) begin
        n_checks++;
        if (scan_cycles !== exp_x.size()) begin
          n_fail++; $display("[TB] FAIL random box %0d throughput: got %0d cycles, expected %0d", b, scan_cycles, exp_x.size());
        end
      end
      n_checks++;
      if (box_ready !== 1'b1) begin
        n_fail++; $display("[TB] FAIL random box %0d ready after: got %b, expected 1", b, box_ready);
      end
    end
  endtask

  task automatic test_clip();
    run_box(16'd38272, 16'd40960, 16'd0, 16'd0, 0, 100);
    build_expected(16'd38272, 16'd40960, 16'd0, 16'd0);
    n_checks++; if (obs_x.size() !== exp_x.size()) begin n_fail++; $display("[TB] FAIL clip count: got %0d, expected %0d", obs_x.size(), exp_x.size()); end
    else foreach (exp_x[i]) begin
      n_checks++;
      if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_last[i] !== exp_last[i]) begin
        n_fail++; $display("[TB] FAIL clip pixel %0d: got (%0d,%0d,%b), expected (%0d,%0d,%b)", i, obs_x[i], obs_y[i], obs_last[i], exp_x[i], exp_y[i], exp_last[i]);
      end
    end
    if (obs_x.size() > 0) begin
      n_checks++;
`ifdef BOX_SCANNER_CLIP_EN
      if (obs_x[obs_x.size()-1] !== 16'd40896) begin n_fail++; $display("[TB] FAIL clip last x: got %0d, expected 40896", obs_x[obs_x.size()-1]); end
`else
      if (obs_x[obs_x.size()-1] !== 16'd40960) begin n_fail++; $display("[TB] FAIL clip last x: got %0d, expected 40960", obs_x[obs_x.size()-1]); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_empty();
    test_backpressure();
    test_top_edge();
    test_reset_midscan();
    test_clip();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
